vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, video fetch has priority over CPU access.
// Define VRAM_ARB_STARVE_EN to add the CPU starvation counter and a 1-deep deferred video slot.
module vram_arbiter #(
   parameter int AW      = 14,
   parameter int DW      = 8,
   parameter int MAXWAIT = 15
) (
   input  logic          pxclk,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_valid,
   output logic [DW-1:0] vid_data,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;
   tag_t          tag1, tag2;
   logic          cpu_pend, cpu_elig, grant_vid, grant_cpu;
   logic [AW-1:0] gvid_addr;
   if (MAXWAIT < 1) begin : g_bad_maxwait
      $error("MAXWAIT must be at least 1");
   end
   assign cpu_elig = cpu_req && !cpu_pend;
`ifdef VRAM_ARB_STARVE_EN
   localparam int CW = $clog2(MAXWAIT + 2);
   logic [CW-1:0] wait_cnt;
   logic          def_valid, def_load, force_cpu;
   logic [AW-1:0] def_addr;
   assign force_cpu = cpu_elig && (wait_cnt >= CW'(MAXWAIT));
   // A pending deferred fetch keeps the slot busy, so a new fetch queues behind it.
   always_comb begin
      grant_cpu = force_cpu || (cpu_elig && !vid_req && !def_valid);
      grant_vid = !force_cpu && (vid_req || def_valid);
      gvid_addr = def_valid ? def_addr : vid_addr;
      def_load  = vid_req && (force_cpu || def_valid);
   end
   always_ff @(posedge pxclk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         def_valid <= 1'b0;
         def_addr  <= '0;
      end else begin
         wait_cnt  <= grant_cpu ? '0 : (cpu_elig && wait_cnt < CW'(MAXWAIT)) ? wait_cnt + CW'(1) : wait_cnt;
         def_valid <= def_load || (def_valid && force_cpu);
         if (def_load) def_addr <= vid_addr;
      end
   end
`else
   always_comb begin
      grant_vid = vid_req;
      grant_cpu = cpu_elig && !vid_req;
      gvid_addr = vid_addr;
   end
`endif
   always_ff @(posedge pxclk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         tag1      <= TAG_NONE;
         tag2      <= TAG_NONE;
         cpu_pend  <= 1'b0;
         vid_data  <= '0;
         cpu_rdata <= '0;
      end else begin
         mem_addr  <= grant_vid ? gvid_addr : grant_cpu ? cpu_addr : mem_addr;
         mem_we    <= grant_cpu && cpu_we;
         mem_wdata <= grant_cpu ? cpu_wdata : mem_wdata;
         tag1      <= grant_vid ? TAG_VID : grant_cpu ? TAG_CPU : TAG_NONE;
         tag2      <= tag1;
         cpu_pend  <= grant_cpu || (cpu_pend && tag2 != TAG_CPU);
         if (tag1 == TAG_VID) vid_data <= mem_rdata;
         if (tag1 == TAG_CPU) cpu_rdata <= mem_rdata;
      end
   end
   assign vid_valid = (tag2 == TAG_VID);
   assign cpu_ack   = (tag2 == TAG_CPU);
endmodule
